// File: rtl/matrix_gen_ctrl.sv
// matrix_gen_ctrl: sequencer between the command parser and the random matrix
// generator. Validates a generate command, starts the generator, stores its
// element stream into round-robin storage slots, emits per-matrix metadata and
// reports completion or a coded error.
module matrix_gen_ctrl #(
  parameter int MAX_DIM   = 5,
  parameter int MAX_COUNT = 8,
  parameter int NUM_SLOTS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_m,
  input  logic [2:0] cmd_n,
  input  logic [3:0] cmd_count,
  input  logic [7:0] cmd_min,
  input  logic [7:0] cmd_max,
  output logic       gen_start,
  output logic [2:0] gen_m,
  output logic [2:0] gen_n,
  output logic [3:0] gen_count,
  output logic [7:0] gen_min,
  output logic [7:0] gen_max,
  input  logic       gen_write_en,
  input  logic [7:0] gen_data,
  input  logic       gen_done,
  output logic       store_we,
  output logic [7:0] store_addr,
  output logic [7:0] store_data,
  output logic       meta_we,
  output logic [2:0] meta_slot,
  output logic [2:0] meta_m,
  output logic [2:0] meta_n,
  output logic       done,
  output logic [2:0] first_slot,
  output logic       err,
  output logic [2:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_RUN, S_FINISH, S_ERROR
  } state_e;

  localparam logic [7:0] STRIDE    = 8'(MAX_DIM * MAX_DIM);
  localparam logic [2:0] DIM_MAX   = 3'(MAX_DIM);
  localparam logic [3:0] CNT_MAX   = 4'(MAX_COUNT);
  localparam logic [2:0] SLOT_LAST = 3'(NUM_SLOTS - 1);
  localparam logic [7:0] TMO_LIM   = 8'(TIMEOUT);

  localparam logic [2:0] ERR_DIM   = 3'd1;
  localparam logic [2:0] ERR_COUNT = 3'd2;
  localparam logic [2:0] ERR_RANGE = 3'd3;
  localparam logic [2:0] ERR_TMO   = 3'd4;
  localparam logic [2:0] ERR_SHORT = 3'd5;

  state_e state_q, state_d;

  logic [2:0] m_q, m_d, n_q, n_d;
  logic [3:0] count_q, count_d;
  logic [7:0] min_q, min_d, max_q, max_d;
  logic [2:0] slot_q, slot_d;
  logic [4:0] idx_q, idx_d, idx_nx;
  logic [3:0] mat_q, mat_d, mat_nx;
  logic [7:0] tmo_q, tmo_d;
  logic [2:0] first_slot_q, first_slot_d;
  logic [2:0] err_code_q, err_code_d;
  logic       store_we_q, store_we_d;
  logic [7:0] store_addr_q, store_addr_d;
  logic [7:0] store_data_q, store_data_d;
  logic       meta_we_q, meta_we_d;
  logic [2:0] meta_slot_q, meta_slot_d;
  logic [2:0] meta_m_q, meta_m_d, meta_n_q, meta_n_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       gen_start_q, gen_start_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  // Elements per matrix; 3x3 bits never exceeds 6 bits.
  logic [5:0] elems;
  logic       last_elem;
  logic       dim_bad, cnt_bad, range_bad;

  assign elems     = {3'b000, m_q} * {3'b000, n_q};
  assign last_elem = ({1'b0, idx_q} == elems - 6'd1);
  assign dim_bad   = (m_q == 3'd0) || (m_q > DIM_MAX) || (n_q == 3'd0) || (n_q > DIM_MAX);
  assign cnt_bad   = (count_q == 4'd0) || (count_q > CNT_MAX);
  assign range_bad = (min_q > max_q);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath: command capture, checks, element capture.
  // NOTE: every signal gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    n_d          = n_q;
    count_d      = count_q;
    min_d        = min_q;
    max_d        = max_q;
    slot_d       = slot_q;
    idx_d        = idx_q;
    mat_d        = mat_q;
    tmo_d        = tmo_q;
    first_slot_d = first_slot_q;
    err_code_d   = err_code_q;
    store_we_d   = 1'b0;
    store_addr_d = store_addr_q;
    store_data_d = store_data_q;
    meta_we_d    = 1'b0;
    meta_slot_d  = meta_slot_q;
    meta_m_d     = meta_m_q;
    meta_n_d     = meta_n_q;
    idx_nx       = idx_q;
    mat_nx       = mat_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          m_d        = cmd_m;
          n_d        = cmd_n;
          count_d    = cmd_count;
          min_d      = cmd_min;
          max_d      = cmd_max;
          err_code_d = 3'd0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dim_bad) begin
          err_code_d = ERR_DIM;
          state_d    = S_ERROR;
        end else if (cnt_bad) begin
          err_code_d = ERR_COUNT;
          state_d    = S_ERROR;
        end else if (range_bad) begin
          err_code_d = ERR_RANGE;
          state_d    = S_ERROR;
        end else begin
          first_slot_d = slot_q;
          state_d      = S_START;
        end
      end
      S_START: begin
        idx_d   = 5'd0;
        mat_d   = 4'd0;
        tmo_d   = 8'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (gen_write_en) begin
          store_we_d   = 1'b1;
          store_data_d = gen_data;
          store_addr_d = {5'b00000, slot_q} * STRIDE + {3'b000, idx_q};
          tmo_d        = 8'd0;
          if (last_elem) begin
            idx_nx      = 5'd0;
            mat_nx      = mat_q + 4'd1;
            meta_we_d   = 1'b1;
            meta_slot_d = slot_q;
            meta_m_d    = m_q;
            meta_n_d    = n_q;
            slot_d      = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
          end else begin
            idx_nx = idx_q + 5'd1;
          end
        end
        idx_d = idx_nx;
        mat_d = mat_nx;
        // Completion is judged after the coincident element, if any.
        if (gen_done) begin
          if ((mat_nx != count_q) || (idx_nx != 5'd0)) begin
            err_code_d = ERR_SHORT;
            state_d    = S_ERROR;
          end else begin
            state_d = S_FINISH;
          end
        end else if (!gen_write_en) begin
          if (tmo_q + 8'd1 == TMO_LIM) begin
            err_code_d = ERR_TMO;
            state_d    = S_ERROR;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes registered from the next state so outputs are
  // glitch-free and all zero while reset is asserted.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    gen_start_d = (state_d == S_START);
    done_d      = (state_d == S_FINISH);
    err_d       = (state_d == S_ERROR);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q          <= '0;
      n_q          <= '0;
      count_q      <= '0;
      min_q        <= '0;
      max_q        <= '0;
      slot_q       <= '0;
      idx_q        <= '0;
      mat_q        <= '0;
      tmo_q        <= '0;
      first_slot_q <= '0;
      err_code_q   <= '0;
      store_we_q   <= 1'b0;
      store_addr_q <= '0;
      store_data_q <= '0;
      meta_we_q    <= 1'b0;
      meta_slot_q  <= '0;
      meta_m_q     <= '0;
      meta_n_q     <= '0;
      cmd_ready_q  <= 1'b0;
      gen_start_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      m_q          <= m_d;
      n_q          <= n_d;
      count_q      <= count_d;
      min_q        <= min_d;
      max_q        <= max_d;
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      mat_q        <= mat_d;
      tmo_q        <= tmo_d;
      first_slot_q <= first_slot_d;
      err_code_q   <= err_code_d;
      store_we_q   <= store_we_d;
      store_addr_q <= store_addr_d;
      store_data_q <= store_data_d;
      meta_we_q    <= meta_we_d;
      meta_slot_q  <= meta_slot_d;
      meta_m_q     <= meta_m_d;
      meta_n_q     <= meta_n_d;
      cmd_ready_q  <= cmd_ready_d;
      gen_start_q  <= gen_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign gen_start  = gen_start_q;
  assign gen_m      = m_q;
  assign gen_n      = n_q;
  assign gen_count  = count_q;
  assign gen_min    = min_q;
  assign gen_max    = max_q;
  assign store_we   = store_we_q;
  assign store_addr = store_addr_q;
  assign store_data = store_data_q;
  assign meta_we    = meta_we_q;
  assign meta_slot  = meta_slot_q;
  assign meta_m     = meta_m_q;
  assign meta_n     = meta_n_q;
  assign done       = done_q;
  assign first_slot = first_slot_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_matrix_gen_ctrl.sv
// Testbench for matrix_gen_ctrl: scoreboard of expected storage and metadata
// writes, filled as generator strobes are driven and drained by a monitor.
module tb_matrix_gen_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_m, cmd_n;
  logic [3:0] cmd_count;
  logic [7:0] cmd_min, cmd_max;
  logic       gen_start;
  logic [2:0] gen_m, gen_n;
  logic [3:0] gen_count;
  logic [7:0] gen_min, gen_max;
  logic       gen_write_en;
  logic [7:0] gen_data;
  logic       gen_done;
  logic       store_we;
  logic [7:0] store_addr, store_data;
  logic       meta_we;
  logic [2:0] meta_slot, meta_m, meta_n;
  logic       done;
  logic [2:0] first_slot;
  logic       err;
  logic [2:0] err_code;

  matrix_gen_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_count(cmd_count),
    .cmd_min(cmd_min), .cmd_max(cmd_max),
    .gen_start(gen_start), .gen_m(gen_m), .gen_n(gen_n),
    .gen_count(gen_count), .gen_min(gen_min), .gen_max(gen_max),
    .gen_write_en(gen_write_en), .gen_data(gen_data), .gen_done(gen_done),
    .store_we(store_we), .store_addr(store_addr), .store_data(store_data),
    .meta_we(meta_we), .meta_slot(meta_slot), .meta_m(meta_m), .meta_n(meta_n),
    .done(done), .first_slot(first_slot), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Scoreboard queues: {addr, data} and {slot, m, n}.
  logic [15:0] store_q[$];
  logic [8:0]  meta_q[$];

  // Reference model of slot allocation.
  int mslot = 0, midx = 0, mm = 0, mn = 0;

  // Monitor: compare every storage / metadata write against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && store_we) begin
      if (store_q.size() == 0) check("store_unexpected", {24'd0, store_addr}, 32'hFFFF);
      else check("store_addr_data", {16'd0, store_addr, store_data}, {16'd0, store_q.pop_front()});
    end
    if (rst_n && meta_we) begin
      if (meta_q.size() == 0) check("meta_unexpected", {29'd0, meta_slot}, 32'hFFFF);
      else check("meta_slot_m_n", {23'd0, meta_slot, meta_m, meta_n}, {23'd0, meta_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check("reset_outputs_zero",
          {31'd0, |{cmd_ready, gen_start, gen_m, gen_n, gen_count, gen_min, gen_max,
                    store_we, store_addr, store_data, meta_we, meta_slot, meta_m,
                    meta_n, done, first_slot, err, err_code}}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mslot = 0;
    store_q.delete();
    meta_q.delete();
  endtask

  // Present a command for one edge; returns #1 after the accept edge.
  task automatic accept(input int m, input int n, input int c, input int lo, input int hi);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 1);
    cmd_m = 3'(m); cmd_n = 3'(n); cmd_count = 4'(c);
    cmd_min = 8'(lo); cmd_max = 8'(hi);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    mm = m; mn = n; midx = 0;
    check("gen_start_not_yet", {31'd0, gen_start}, 0);
  endtask

  // For a legal command: check the start pulse, then advance into RUN.
  task automatic expect_start(input int m, input int n, input int c);
    step();
    check("gen_start_pulse", {31'd0, gen_start}, 1);
    check("gen_held_params", {21'd0, gen_m, gen_n, gen_count}, {21'd0, 3'(m), 3'(n), 4'(c)});
    step();
    check("gen_start_one_cycle", {31'd0, gen_start}, 0);
  endtask

  // Drive one generator strobe and push the expected writes.
  task automatic strobe(input int data, input bit with_done);
    store_q.push_back({8'(mslot * 25 + midx), 8'(data)});
    if (midx == mm * mn - 1) begin
      meta_q.push_back({3'(mslot), 3'(mm), 3'(mn)});
      midx = 0;
      mslot = (mslot + 1) % 8;
    end else begin
      midx++;
    end
    gen_write_en = 1'b1;
    gen_data = 8'(data);
    gen_done = with_done;
    step();
    gen_write_en = 1'b0;
    gen_done = 1'b0;
  endtask

  task automatic pulse_done();
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
  endtask

  // Wait (bounded) for done or err and check the outcome.
  task automatic expect_result(input bit exp_done, input int exp_code, input int exp_first);
    int cyc = 0;
    while (!(done || err) && cyc < 50) begin
      step();
      cyc++;
    end
    check("result_done", {31'd0, done}, {31'd0, exp_done});
    check("result_err", {31'd0, err}, {31'd0, !exp_done});
    check("result_err_code", {29'd0, err_code}, 32'(exp_code));
    if (exp_done) check("result_first_slot", {29'd0, first_slot}, 32'(exp_first));
    step();
    check("ready_after_result", {31'd0, cmd_ready}, 1);
    check("result_pulse_one_cycle", {30'd0, done, err}, 0);
  endtask

  task automatic run_ones(input int c);
    int fs = mslot;
    accept(1, 1, c, 0, 255);
    expect_start(1, 1, c);
    for (int i = 0; i < c; i++) strobe(100 + i, i == c - 1);
    expect_result(1'b1, 0, fs);
  endtask

  initial begin
    int fs;
    int cyc;
    cmd_valid = 0; cmd_m = 0; cmd_n = 0; cmd_count = 0; cmd_min = 0; cmd_max = 0;
    gen_write_en = 0; gen_data = 0; gen_done = 0;
    do_reset();

    // Strobe while idle must not write storage.
    gen_write_en = 1'b1; gen_data = 8'hAA;
    step();
    gen_write_en = 1'b0;
    step();

    // Basic 2x3, two matrices from reset.
    accept(2, 3, 2, 0, 9);
    expect_start(2, 3, 2);
    for (int i = 1; i <= 12; i++) strobe(i, 1'b0);
    pulse_done();
    expect_result(1'b1, 0, 0);
    check("model_slot_after_basic", 32'(mslot), 2);
    run_ones(1);  // starts at slot 2

    // Illegal parameters.
    accept(0, 3, 1, 0, 9);  step(); check("no_start_dim_m", {31'd0, gen_start}, 0); expect_result(1'b0, 1, 0);
    accept(2, 6, 1, 0, 9);  step(); check("no_start_dim_n", {31'd0, gen_start}, 0); expect_result(1'b0, 1, 0);
    accept(2, 2, 0, 0, 9);  step(); check("no_start_cnt0",  {31'd0, gen_start}, 0); expect_result(1'b0, 2, 0);
    accept(2, 2, 9, 0, 9);  step(); check("no_start_cnt9",  {31'd0, gen_start}, 0); expect_result(1'b0, 2, 0);
    accept(2, 2, 1, 10, 3); step(); check("no_start_range", {31'd0, gen_start}, 0); expect_result(1'b0, 3, 0);

    // Slot wrap: advance pointer 3 -> 7, then 3 single-element matrices.
    run_ones(4);
    check("model_slot_before_wrap", 32'(mslot), 7);
    run_ones(3);   // addresses 175, 0, 25
    run_ones(1);   // first_slot 2

    // Stall: 3 of 4 elements, then silence.
    fs = mslot;
    accept(2, 2, 1, 0, 255);
    expect_start(2, 2, 1);
    for (int i = 0; i < 3; i++) strobe(50 + i, 1'b0);
    cyc = 0;
    while (!err && cyc < 400) begin
      step();
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), 255);
    check("timeout_code", {29'd0, err_code}, 4);
    step();
    check("ready_after_timeout", {31'd0, cmd_ready}, 1);
    mslot = fs;  // partial matrix does not advance the slot

    // Short run: 5 of 6 elements, 5th coincident with gen_done.
    accept(2, 3, 1, 0, 255);
    expect_start(2, 3, 1);
    for (int i = 0; i < 5; i++) strobe(60 + i, i == 4);
    expect_result(1'b0, 5, 0);
    mslot = fs;

    // Reset in the middle of RUN.
    accept(1, 2, 2, 0, 255);
    expect_start(1, 2, 2);
    strobe(77, 1'b0);
    @(negedge clk);
    #2;
    do_reset();
    step();
    run_ones(1);   // first_slot 0, address 0

    repeat (3) step();
    check("store_queue_drained", 32'(store_q.size()), 0);
    check("meta_queue_drained", 32'(meta_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
